// File: rtl/usb_rx_pkg.sv
// usb_rx_pkg: receiver states and protocol constants shared by the USB RX byte assembler
package usb_rx_pkg;
  typedef enum logic [2:0] {IDLE, SYNC, DATA, EOP, ERR} rx_state_t;
  localparam logic [7:0] SYNC_BYTE = 8'h80;
  localparam int STUFF_LIMIT = 6;
  localparam int IDLE_BITS = 8;
endpackage

// File: rtl/usb_rx_bit_timer.sv
// usb_rx_bit_timer: D+ edge detect and bit-time counter (i_dp, i_se0 in; o_strobe mid-bit sample, o_fall J->K edge out)
module usb_rx_bit_timer #(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic i_dp,
  input  logic i_se0,
  output logic o_strobe,
  output logic o_fall
);
  localparam int W = $clog2(CLKS_PER_BIT);
  logic [W-1:0] r_cnt;
  logic r_dp;
  logic w_edge;
  // edges into SE0 carry no timing information, so they do not resync
  assign w_edge = (i_dp != r_dp) && !i_se0;
  assign o_fall = r_dp && !i_dp;
  assign o_strobe = r_cnt == W'(CLKS_PER_BIT / 2 - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_dp <= 1'b1;
    end else begin
      r_dp <= i_dp;
      r_cnt <= (w_edge || r_cnt == W'(CLKS_PER_BIT - 1)) ? '0 : r_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/usb_rx_byte_assembler.sv
// usb_rx_byte_assembler: USB FS receive front end (dp_sync/dm_sync in; p_out, load_buf, flush, eop, rcv_error, receiving out)
module usb_rx_byte_assembler
  import usb_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       dp_sync,
  input  logic       dm_sync,
  output logic [7:0] p_out,
  output logic       load_buf,
  output logic       flush,
  output logic       eop,
  output logic       rcv_error,
  output logic       receiving
);
  rx_state_t r_state, w_next;
  logic       r_prev_line;
  logic [2:0] r_ones, r_bit_cnt;
  logic [7:0] r_shift, w_byte;
  logic [3:0] r_cnt, w_cnt;
  logic w_se0, w_j, w_k, w_strobe, w_fall, w_bit, w_stuff, w_last;
  logic w_keep, w_drop, w_load, w_flush, w_eop, w_err;

  usb_rx_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk(clk),
    .rst(rst),
    .i_dp(dp_sync),
    .i_se0(w_se0),
    .o_strobe(w_strobe),
    .o_fall(w_fall)
  );

  // dp1/dm1 is an illegal line state and is folded into SE0
  assign w_se0 = dp_sync == dm_sync;
  assign w_j = !w_se0 && dp_sync;
  assign w_k = !w_se0 && !dp_sync;
  assign w_bit = dp_sync == r_prev_line;
  assign w_stuff = r_ones == 3'(STUFF_LIMIT);
  assign w_byte = {w_bit, r_shift[7:1]};
  assign w_last = r_bit_cnt == 3'd7;
  assign receiving = r_state != IDLE;

  // r_cnt counts SE0 strobes in EOP and consecutive J strobes in ERR
  always_comb begin
    w_next = r_state;
    w_cnt = r_cnt;
    w_keep = 1'b0;
    w_drop = 1'b0;
    w_load = 1'b0;
    w_flush = 1'b0;
    w_eop = 1'b0;
    w_err = 1'b0;
    case (r_state)
      IDLE: if (w_fall && w_k) w_next = SYNC;
      SYNC, DATA: if (w_strobe) begin
        if (w_se0) begin
          w_next = (r_state == DATA) ? EOP : ERR;
          w_err = r_state == SYNC;
          w_cnt = 4'd1;
        end else if (w_stuff) begin
          w_drop = !w_bit;
          w_err = w_bit;
          w_next = w_bit ? ERR : r_state;
        end else begin
          w_keep = 1'b1;
          if (w_last && r_state == SYNC) begin
            w_flush = w_byte == SYNC_BYTE;
            w_err = !w_flush;
            w_next = w_flush ? DATA : ERR;
          end else if (w_last) w_load = 1'b1;
        end
      end
      EOP: if (w_strobe) begin
        if (w_se0) begin
          w_cnt = r_cnt + 4'd1;
          w_err = r_cnt == 4'd3;
          w_next = w_err ? ERR : EOP;
        end else if (w_j && r_cnt >= 4'd2) begin
          w_next = IDLE;
          w_eop = r_bit_cnt == 3'd0;
          w_err = !w_eop;
        end else begin
          w_next = ERR;
          w_err = 1'b1;
        end
      end
      ERR: if (w_strobe) begin
        w_cnt = w_j ? r_cnt + 4'd1 : 4'd0;
        if (w_j && r_cnt == 4'(IDLE_BITS - 1)) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
    if (w_next == ERR && r_state != ERR) w_cnt = 4'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_prev_line <= 1'b1;
      r_ones <= '0;
      r_bit_cnt <= '0;
      r_shift <= '0;
      r_cnt <= '0;
      p_out <= '0;
      load_buf <= 1'b0;
      flush <= 1'b0;
      eop <= 1'b0;
      rcv_error <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt <= w_cnt;
      load_buf <= w_load;
      flush <= w_flush;
      eop <= w_eop;
      if (w_load) p_out <= w_byte;
      if (w_err) rcv_error <= 1'b1;
      else if (w_flush) rcv_error <= 1'b0;
      if (r_state == IDLE) begin
        r_prev_line <= 1'b1;
        r_ones <= '0;
        r_bit_cnt <= '0;
        r_shift <= '0;
      end else begin
        if (w_strobe && !w_se0) r_prev_line <= dp_sync;
        if (w_drop) r_ones <= '0;
        else if (w_keep) r_ones <= w_bit ? r_ones + 3'd1 : 3'd0;
        if (w_keep) begin
          r_shift <= w_byte;
          r_bit_cnt <= r_bit_cnt + 3'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_usb_rx_byte_assembler.sv
// tb_usb_rx_byte_assembler: table-driven packets plus reset corner cases for the USB RX byte assembler
module tb_usb_rx_byte_assembler;
  localparam int CPB = 8;
  logic clk = 1'b0, rst = 1'b1, dp_sync = 1'b1, dm_sync = 1'b0;
  logic [7:0] p_out;
  logic load_buf, flush, eop, rcv_error, receiving;
  int errors = 0, checks = 0;
  int tot_flush = 0, tot_load = 0, tot_eop = 0, tot_overlap = 0;
  logic [7:0] rx_bytes[$];
  int level, ones;
  bit jit, jp;

  typedef struct {
    logic [7:0]  sync;
    int          nbits;
    logic [31:0] data;
    bit          stuff;
    bit          jit;
    int          e_flush;
    int          e_load;
    int          e_eop;
    int          e_err;
  } vec_t;
  vec_t vecs[7];

  always #5 clk = ~clk;

  usb_rx_byte_assembler #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk),
    .rst(rst),
    .dp_sync(dp_sync),
    .dm_sync(dm_sync),
    .p_out(p_out),
    .load_buf(load_buf),
    .flush(flush),
    .eop(eop),
    .rcv_error(rcv_error),
    .receiving(receiving)
  );

  always @(negedge clk) begin
    if (flush) tot_flush++;
    if (eop) tot_eop++;
    if (flush && load_buf) tot_overlap++;
    if (load_buf) begin
      tot_load++;
      rx_bytes.push_back(p_out);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // sym: 0 = K, 1 = J, 2 = SE0; held for len clocks starting at a negedge
  task automatic drive(input int sym, input int len);
    dp_sync = (sym == 1);
    dm_sync = (sym == 0);
    repeat (len) @(negedge clk);
  endtask

  task automatic tx_bit(input bit b);
    int len;
    if (!b) level = 1 - level;
    len = CPB + (jit ? (jp ? -2 : 2) : 0);
    jp = !jp;
    drive(level, len);
  endtask

  task automatic tx_data_bit(input bit b, input bit stuff);
    tx_bit(b);
    ones = b ? ones + 1 : 0;
    if (stuff && ones == 6) begin
      tx_bit(1'b0);
      ones = 0;
    end
  endtask

  task automatic tx_start(input logic [7:0] sync, input bit j);
    jit = 1'b0;
    level = 1;
    drive(1, 3 * CPB);
    jit = j;
    jp = 1'b0;
    ones = 0;
    for (int i = 0; i < 8; i++) tx_data_bit(sync[i], 1'b1);
  endtask

  task automatic send_packet(input logic [7:0] sync, input int nbits, input logic [31:0] data,
                             input bit stuff, input bit j);
    tx_start(sync, j);
    for (int i = 0; i < nbits; i++) tx_data_bit(data[i], stuff);
    jit = 1'b0;
    drive(2, 2 * CPB);
    drive(1, 11 * CPB);
  endtask

  task automatic check_packet(input string tag, input vec_t v, input int f0, input int l0,
                              input int e0, input int b0);
    chk({tag, " flush"}, tot_flush - f0, v.e_flush);
    chk({tag, " load_buf"}, tot_load - l0, v.e_load);
    chk({tag, " eop"}, tot_eop - e0, v.e_eop);
    chk({tag, " rcv_error"}, int'(rcv_error), v.e_err);
    chk({tag, " receiving"}, int'(receiving), 0);
    for (int i = 0; i < v.e_load; i++)
      chk($sformatf("%s byte%0d", tag, i),
          (b0 + i < rx_bytes.size()) ? int'(rx_bytes[b0 + i]) : -1, int'(v.data[8*i+:8]));
  endtask

  initial begin
    int f0, l0, e0, b0;
    vec_t rv;
    vecs[0] = '{8'h80, 8, 32'h0000_00A5, 1'b1, 1'b0, 1, 1, 1, 0};
    vecs[1] = '{8'h80, 8, 32'h0000_00FF, 1'b1, 1'b0, 1, 1, 1, 0};
    vecs[2] = '{8'h80, 7, 32'h0000_007F, 1'b0, 1'b0, 1, 0, 0, 1};
    vecs[3] = '{8'h81, 8, 32'h0000_0000, 1'b1, 1'b0, 0, 0, 0, 1};
    vecs[4] = '{8'h80, 24, 32'h0012_FF3C, 1'b1, 1'b0, 1, 3, 1, 0};
    vecs[5] = '{8'h80, 4, 32'h0000_000A, 1'b1, 1'b0, 1, 0, 0, 1};
    vecs[6] = '{8'h80, 16, 32'h0000_5AA5, 1'b1, 1'b1, 1, 2, 1, 0};
    repeat (4) @(negedge clk);
    chk("reset p_out", int'(p_out), 0);
    chk("reset load_buf", int'(load_buf), 0);
    chk("reset flush", int'(flush), 0);
    chk("reset eop", int'(eop), 0);
    chk("reset rcv_error", int'(rcv_error), 0);
    chk("reset receiving", int'(receiving), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle receiving", int'(receiving), 0);

    for (int v = 0; v < 7; v++) begin
      f0 = tot_flush;
      l0 = tot_load;
      e0 = tot_eop;
      b0 = rx_bytes.size();
      send_packet(vecs[v].sync, vecs[v].nbits, vecs[v].data, vecs[v].stuff, vecs[v].jit);
      check_packet($sformatf("vec%0d", v), vecs[v], f0, l0, e0, b0);
    end

    tx_start(8'h80, 1'b0);
    for (int i = 0; i < 4; i++) tx_data_bit(i[0], 1'b1);
    chk("midpkt receiving", int'(receiving), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst p_out", int'(p_out), 0);
    chk("midrst receiving", int'(receiving), 0);
    chk("midrst load_buf", int'(load_buf), 0);
    chk("midrst flush", int'(flush), 0);
    chk("midrst eop", int'(eop), 0);
    chk("midrst rcv_error", int'(rcv_error), 0);
    drive(1, 3);
    rst = 1'b0;
    rv = '{8'h80, 8, 32'h0000_00C3, 1'b1, 1'b0, 1, 1, 1, 0};
    f0 = tot_flush;
    l0 = tot_load;
    e0 = tot_eop;
    b0 = rx_bytes.size();
    send_packet(rv.sync, rv.nbits, rv.data, rv.stuff, rv.jit);
    check_packet("after_rst", rv, f0, l0, e0, b0);
    chk("flush_load_overlap", tot_overlap, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
